// File: rtl/btn_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : btn_event_arbiter                                               |
// | Brief    : Four-channel button press classifier (short/long) with a        |
// |            round-robin single-event output port and sticky overflow flags. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module btn_event_arbiter #(
  parameter int unsigned N          = 13,
  parameter logic [7:0]  LONG_TICKS = 8'd100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] db,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_id,
  output logic       evt_long,
  output logic [3:0] ovf
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  localparam logic [7:0] C_HOLD_MAX = 8'hFF;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_presc;
  logic            w_tick;
  logic [3:0]      r_db_d;
  logic [3:0]      w_rise;
  logic [3:0]      w_fall;
  logic [3:0]      r_pending;
  logic [3:0]      r_long;
  logic [3:0]      w_grant_vec;
  logic [3:0][7:0] r_hold_cnt;
  logic [1:0]      r_last_grant;
  logic [1:0]      w_grant_id;
  logic            w_any_pending;
  logic            w_grant;
  logic            w_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + N'(1);
    end
  end

  assign w_tick        = &r_presc;
  assign w_rise        = db & ~r_db_d;
  assign w_fall        = ~db & r_db_d;
  assign w_any_pending = |r_pending;
  assign evt_valid     = (r_state == S_OFFER);

  // A fall on the channel being granted this cycle re-arms pending without
  // counting as a lost press; the grant consumes the older press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_d     <= '0;
      r_pending  <= '0;
      r_long     <= '0;
      ovf        <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_db_d <= db;
      for (int i = 0; i < 4; i++) begin
        if (w_rise[i]) begin
          r_hold_cnt[i] <= '0;
        end else if (w_tick && db[i] && (r_hold_cnt[i] != C_HOLD_MAX)) begin
          r_hold_cnt[i] <= r_hold_cnt[i] + 8'd1;
        end

        if (w_fall[i]) begin
          r_pending[i] <= 1'b1;
          r_long[i]    <= (r_hold_cnt[i] >= LONG_TICKS);
          if (r_pending[i] && !w_grant_vec[i]) begin
            ovf[i] <= 1'b1;
          end
        end else if (w_grant_vec[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Scan downward so the candidate closest to last_grant+1 wins.
  always_comb begin
    w_grant_id = r_last_grant + 2'd1;
    for (int k = 3; k >= 0; k--) begin
      if (r_pending[r_last_grant + 2'(k + 1)]) begin
        w_grant_id = r_last_grant + 2'(k + 1);
      end
    end
  end

  always_comb begin
    w_grant_vec = '0;
    if (w_grant) begin
      w_grant_vec[w_grant_id] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_pending) begin
          w_grant     = 1'b1;
          w_state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        if (evt_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      evt_id       <= '0;
      evt_long     <= 1'b0;
      r_last_grant <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        evt_id   <= w_grant_id;
        evt_long <= r_long[w_grant_id];
      end
      if (w_accept) begin
        r_last_grant <= evt_id;
      end
    end
  end

endmodule
`default_nettype wire
